// File: rtl/tick_meter_pkg.sv
// tick_meter_pkg: FSM state encoding and default constants for tick_period_meter
package tick_meter_pkg;
  typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;
  localparam int DEF_WIDTH = 20;
  localparam int DEF_EXPECTED = 1000000;
  localparam int DEF_TOL = 2;
endpackage

// File: rtl/tick_period_meter_if.sv
// tick_period_meter_if: measurement bus; master drives Enable/Tick_in and observes Period, Period_valid, Match, Timeout, Err_cnt
interface tick_period_meter_if
  import tick_meter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic Enable;
  logic Tick_in;
  logic [WIDTH-1:0] Period;
  logic Period_valid;
  logic Match;
  logic Timeout;
  logic [7:0] Err_cnt;
  modport master(output Enable, Tick_in, input Period, Period_valid, Match, Timeout, Err_cnt);
  modport slave(input Enable, Tick_in, output Period, Period_valid, Match, Timeout, Err_cnt);
endinterface

// File: rtl/tick_edge_det.sv
// tick_edge_det: rising-edge detector; ports CLK, Clr (sync active-high), In, Rise (combinational In & ~delayed In)
module tick_edge_det (
  input  logic CLK,
  input  logic Clr,
  input  logic In,
  output logic Rise
);
  logic tick_d;
  always_ff @(posedge CLK)
    tick_d <= Clr ? 1'b0 : In;
  assign Rise = In & ~tick_d;
endmodule

// File: rtl/tick_period_meter.sv
// tick_period_meter: measures edge-to-edge tick period; ports CLK, Clr (sync active-high), bus (slave modport); macro TICK_METER_TOLERANCE_EN enables +/-TOL matching
module tick_period_meter
  import tick_meter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int EXPECTED = DEF_EXPECTED,
  parameter int TOL = DEF_TOL
) (
  input  logic CLK,
  input  logic Clr,
  tick_period_meter_if.slave bus
);
`ifdef TICK_METER_TOLERANCE_EN
  localparam logic [31:0] TOL_EFF = 32'(TOL);
`else
  localparam logic [31:0] TOL_EFF = 32'(TOL) & 32'h0;
`endif
  localparam logic [31:0] EXP32 = 32'(EXPECTED);
  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  state_t state;
  logic [WIDTH-1:0] cnt;
  logic rise;
  logic hit;
  logic [31:0] cnt_ext, diff;
  logic [7:0] err_inc;
  tick_edge_det u_edge (.CLK(CLK), .Clr(Clr), .In(bus.Tick_in), .Rise(rise));
  always_comb begin
    cnt_ext = 32'(cnt);
    diff = cnt_ext > EXP32 ? cnt_ext - EXP32 : EXP32 - cnt_ext;
    hit = diff <= TOL_EFF;
    err_inc = bus.Err_cnt == 8'hFF ? bus.Err_cnt : bus.Err_cnt + 8'd1;
  end
  always_ff @(posedge CLK) begin
    if (Clr) begin
      state <= IDLE;
      cnt <= '0;
      bus.Period <= '0;
      bus.Period_valid <= 1'b0;
      bus.Match <= 1'b0;
      bus.Timeout <= 1'b0;
      bus.Err_cnt <= '0;
    end else begin
      bus.Period_valid <= 1'b0;
      bus.Timeout <= 1'b0;
      if (!bus.Enable) begin
        state <= IDLE;
        cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            cnt <= '0;
            state <= ARM;
          end
          ARM: if (rise) begin
            cnt <= WIDTH'(1);
            state <= MEASURE;
          end
          MEASURE: if (rise) begin
            bus.Period <= cnt;
            bus.Period_valid <= 1'b1;
            bus.Match <= hit;
            cnt <= WIDTH'(1);
            if (!hit) bus.Err_cnt <= err_inc;
          end else if (cnt == CNT_MAX) begin
            // saturated without an edge: abandon this period and wait for a fresh reference edge
            bus.Timeout <= 1'b1;
            bus.Err_cnt <= err_inc;
            cnt <= '0;
            state <= ARM;
          end else begin
            cnt <= cnt + WIDTH'(1);
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_tick_period_meter.sv
// tb_tick_period_meter: randomized scoreboard bench for tick_period_meter against a time-stamp reference model
module tb_tick_period_meter;
  localparam int WIDTH = 12;
  localparam int EXPECTED = 1000;
  localparam int TOL = 2;
  localparam int MAX = (1 << WIDTH) - 1;
`ifdef TICK_METER_TOLERANCE_EN
  localparam int TOL_M = TOL;
`else
  localparam int TOL_M = 0;
`endif
  typedef struct {
    bit to;
    int period;
    bit match;
    int err;
  } exp_t;
  logic CLK = 0;
  logic Clr = 0;
  tick_period_meter_if #(.WIDTH(WIDTH)) bus ();
  tick_period_meter #(.WIDTH(WIDTH), .EXPECTED(EXPECTED), .TOL(TOL)) dut (.CLK(CLK), .Clr(Clr), .bus(bus));
  always #5 CLK = ~CLK;
  int n_chk = 0;
  int n_fail = 0;
  exp_t q[$];
  int cyc = 0;
  bit prev_t = 0;
  bit active = 0;
  int t0 = -1;
  int m_period = 0;
  bit m_match = 0;
  int m_err = 0;
  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask
  // Reference: timestamps of tick edges; a period is the distance between consecutive accepted edges.
  task automatic model(input bit e, input bit t, input bit c);
    bit rise;
    int p;
    rise = t & ~prev_t;
    prev_t = c ? 1'b0 : t;
    if (c) begin
      active = 0; t0 = -1; m_period = 0; m_match = 0; m_err = 0;
    end else if (!e) begin
      active = 0; t0 = -1;
    end else if (!active) begin
      active = 1; t0 = -1;
    end else if (rise) begin
      if (t0 >= 0) begin
        p = cyc - t0;
        m_period = p;
        m_match = (p > EXPECTED ? p - EXPECTED : EXPECTED - p) <= TOL_M;
        if (!m_match && m_err < 255) m_err++;
        q.push_back('{0, m_period, m_match, m_err});
      end
      t0 = cyc;
    end else if (t0 >= 0 && cyc - t0 == MAX) begin
      if (m_err < 255) m_err++;
      q.push_back('{1, m_period, m_match, m_err});
      t0 = -1;
    end
    cyc++;
  endtask
  task automatic step(input bit e, input bit t, input bit c);
    @(negedge CLK);
    bus.Enable = e;
    bus.Tick_in = t;
    Clr = c;
    model(e, t, c);
  endtask
  task automatic tick(input int gap, input int hold);
    for (int i = 0; i < gap; i++) step(1, i < hold, 0);
  endtask
  task automatic check_outputs(input string tag);
    @(posedge CLK);
    #1;
    chk({tag, "_period"}, int'(bus.Period), m_period);
    chk({tag, "_match"}, int'(bus.Match), int'(m_match));
    chk({tag, "_err"}, int'(bus.Err_cnt), m_err);
    chk({tag, "_valid"}, int'(bus.Period_valid), 0);
    chk({tag, "_timeout"}, int'(bus.Timeout), 0);
  endtask
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (bus.Period_valid && bus.Timeout) chk("strobe_exclusive", 1, 0);
      if (bus.Period_valid || bus.Timeout) begin
        chk("strobe_expected", int'(q.size() > 0), 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("kind_timeout", int'(bus.Timeout), int'(e.to));
          chk("period", int'(bus.Period), e.period);
          chk("match", int'(bus.Match), int'(e.match));
          chk("err_cnt", int'(bus.Err_cnt), e.err);
        end
      end
    end
  end
  initial begin
    bus.Enable = 0;
    bus.Tick_in = 0;
    Clr = 1;
    for (int i = 0; i < 3; i++) step(0, 0, 1);
    check_outputs("reset");
    step(1, 0, 0);
    for (int i = 0; i < 4; i++) tick(EXPECTED, 1);
    for (int i = 0; i < 3; i++) tick(EXPECTED - 2, 1);
    for (int i = 0; i < 3; i++) tick(EXPECTED, 5);
    tick(4200, 1);
    tick(MAX, 1);
    tick(MAX, 1);
    tick(MAX + 1, 1);
    tick(10, 1);
    tick(EXPECTED, 1);
    tick(500, 1);
    step(1, 0, 1);
    check_outputs("clr_mid");
    tick(EXPECTED, 1);
    tick(EXPECTED, 1);
    tick(EXPECTED, 1);
    tick(400, 1);
    for (int i = 0; i < 10; i++) step(0, 0, 0);
    tick(EXPECTED, 1);
    tick(EXPECTED, 1);
    tick(EXPECTED, 1);
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 9) == 0)
        for (int j = 0; j < int'($urandom_range(1, 12)); j++) step(0, $urandom_range(0, 1), 0);
      tick(EXPECTED + int'($urandom_range(0, 10)) - 5, int'($urandom_range(1, 5)));
    end
    for (int i = 0; i < 300; i++) tick(int'($urandom_range(20, 60)), int'($urandom_range(1, 3)));
    for (int i = 0; i < 5; i++) step(0, 0, 0);
    check_outputs("final");
    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/tick_period_meter.md
TICK_PERIOD_METER -- requirements
Module: tick_period_meter

Interface
REQ-001 Parameter WIDTH, default 20: width of the period counter and of Period.
REQ-002 Parameter EXPECTED, default 1000000: nominal tick period in CLK cycles.
REQ-003 Parameter TOL, default 2: allowed deviation in cycles; used only when tolerance matching is compiled in.
REQ-004 CLK  input  1  the single clock; every register SHALL update on its rising edge.
REQ-005 Clr  input  1  reset; synchronous and active-high.
REQ-006 Enable  input  1  measurement enable (level).
REQ-007 Tick_in  input  1  tick stream under test, one pulse per period, from a 1E6 counter output.
REQ-008 Period  output  WIDTH  last measured edge-to-edge period in cycles.
REQ-009 Period_valid  output  1  one-cycle strobe marking a new Period.
REQ-010 Match  output  1  the last Period met EXPECTED; updated with Period_valid.
REQ-011 Timeout  output  1  one-cycle strobe: no tick before the counter saturated.
REQ-012 Err_cnt  output  8  saturating count of mismatches and timeouts.

Function
REQ-013 The block SHALL register Tick_in into Tick_d and SHALL define the edge as Tick_in & ~Tick_d, so a held-high input counts once.
REQ-014 The FSM SHALL have states IDLE, ARM and MEASURE.
REQ-015 IDLE: when Enable=1, go to ARM. Counter stays 0.
REQ-016 ARM: on the first edge, load counter with 1 and go to MEASURE. No Period_valid is issued.
REQ-017 MEASURE: the counter SHALL increment by 1 each cycle without an edge.
REQ-018 On an edge in MEASURE, the block SHALL load Period with the counter value, pulse Period_valid and update Match in the same clock edge, then reload the counter with 1.
REQ-019 Edges at cycles t0 and t1 SHALL yield Period = t1 - t0, with Period_valid high during cycle t1+1.
REQ-020 If the counter reaches 2^WIDTH-1 with no edge, the block SHALL pulse Timeout, increment Err_cnt, clear the counter and go to ARM. Period and Match SHALL hold.
REQ-021 An edge in the same cycle the counter reaches 2^WIDTH-1 SHALL be treated as a normal measurement, and Timeout SHALL stay 0.
REQ-022 Enable=0 in any state SHALL return the FSM to IDLE on the next cycle and clear the counter. Period, Match and Err_cnt SHALL hold, and no strobe is issued.
REQ-023 Err_cnt SHALL increment on each Period_valid with Match=0 and on each Timeout, and SHALL saturate at 255.
REQ-024 Period_valid and Timeout SHALL never be high in the same cycle.

Reset
REQ-025 Clr=1 at a rising CLK edge SHALL force the FSM to IDLE and Tick_d, counter, Period, Period_valid, Match, Timeout and Err_cnt to 0, overriding every other input.
REQ-026 Clr asserted mid-measurement SHALL discard the partial count, and the first edge after release SHALL only re-arm.

Configuration
REQ-027 With macro TICK_METER_TOLERANCE_EN defined, Match SHALL be 1 when |Period - EXPECTED| <= TOL.
REQ-028 Without that macro, Match SHALL be 1 only when Period == EXPECTED, and TOL is unused.

Structure
REQ-029 Package tick_meter_pkg SHALL hold the state encoding (IDLE, ARM, MEASURE) and the default constants for WIDTH, EXPECTED and TOL.
REQ-030 Edge detection SHALL be a sub-module named tick_edge_det (inputs CLK, Clr, In; output Rise).
REQ-031 The counter, FSM and compare logic SHALL stay in tick_period_meter.

Verification
REQ-032 Enable=1, ticks every 1000000 cycles -> first Period_valid at the 2nd tick + 1 cycle; Period=1000000, Match=1, Err_cnt=0.
REQ-033 Ticks spaced 999998 apart -> Match=0 and Err_cnt=1 without the macro; Match=1 and Err_cnt=0 with the macro (TOL=2).
REQ-034 One tick, then none for 1048575 cycles -> one Timeout pulse, Err_cnt=1, FSM back in ARM; Period keeps its prior value.
REQ-035 Tick_in held high for 5 cycles, rising edges 1000 apart -> Period=1000, and the hold produces no extra strobes.
REQ-036 Clr=1 for 1 cycle midway through a period -> all outputs 0; the next tick arms only; the following tick gives the correct Period.
REQ-037 Enable dropped for 10 cycles mid-period -> FSM IDLE, no strobe; after re-enable, two ticks are needed for the next Period_valid.
